// File: rtl/rtc_counter.sv
// rtl/rtc_counter.sv - BCD real-time clock with prescaler, validated load and 12/24-hour display
//
// Keeps time internally as six BCD digits in 24-hour form. A prescaler divides
// sys_clk down to TICK_HZ; each tick advances the time by one second.
//
// Ports:
//   sys_clk          clock, all state on rising edge
//   rst              synchronous active-high reset
//   run              1 = prescaler/time advance, 0 = hold
//   mode_24h         display mapping select (1 = 24h, 0 = 12h)
//   load             single-cycle load request for set_* digits
//   set_h_t..set_s_o load digits, 24-hour BCD
//   hours_tens..seconds_ones  displayed BCD digits (combinational)
//   pm               internal hour >= 12
//   sec_tick         one-cycle pulse when incremented digits first appear
//   day_wrap         one-cycle pulse on the 23:59:59 -> 00:00:00 increment
//   load_err         one-cycle pulse in the cycle after a rejected load

module rtc_counter #(
    parameter int unsigned CLK_HZ  = 100000000,
    parameter int unsigned TICK_HZ = 1
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       run,
    input  logic       mode_24h,
    input  logic       load,
    input  logic [3:0] set_h_t,
    input  logic [3:0] set_h_o,
    input  logic [3:0] set_m_t,
    input  logic [3:0] set_m_o,
    input  logic [3:0] set_s_t,
    input  logic [3:0] set_s_o,
    output logic [3:0] hours_tens,
    output logic [3:0] hours_ones,
    output logic [3:0] minutes_tens,
    output logic [3:0] minutes_ones,
    output logic [3:0] seconds_tens,
    output logic [3:0] seconds_ones,
    output logic       pm,
    output logic       sec_tick,
    output logic       day_wrap,
    output logic       load_err
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    h_t_q, h_o_q, m_t_q, m_o_q, s_t_q, s_o_q;
    logic [3:0]    h_t_d, h_o_d, m_t_d, m_o_d, s_t_d, s_o_d;
    logic          sec_tick_q, sec_tick_d;
    logic          day_wrap_q, day_wrap_d;
    logic          load_err_q, load_err_d;

    // ------------------------------------------------------------------
    // Tick: prescaler sits at its maximum while running
    // ------------------------------------------------------------------
    logic tick;
    assign tick = run && (presc_q == PRESC_MAX);

    // ------------------------------------------------------------------
    // One-second BCD increment with ripple carries
    // ------------------------------------------------------------------
    logic [3:0] inc_h_t, inc_h_o, inc_m_t, inc_m_o, inc_s_t, inc_s_o;
    logic       at_day_end;

    assign at_day_end = (h_t_q == 4'd2) && (h_o_q == 4'd3) &&
                        (m_t_q == 4'd5) && (m_o_q == 4'd9) &&
                        (s_t_q == 4'd5) && (s_o_q == 4'd9);

    always_comb begin
        inc_h_t = h_t_q;
        inc_h_o = h_o_q;
        inc_m_t = m_t_q;
        inc_m_o = m_o_q;
        inc_s_t = s_t_q;
        inc_s_o = s_o_q;
        if (s_o_q == 4'd9) begin
            inc_s_o = 4'd0;
            if (s_t_q == 4'd5) begin
                inc_s_t = 4'd0;
                if (m_o_q == 4'd9) begin
                    inc_m_o = 4'd0;
                    if (m_t_q == 4'd5) begin
                        inc_m_t = 4'd0;
                        if ((h_t_q == 4'd2) && (h_o_q == 4'd3)) begin
                            inc_h_t = 4'd0;
                            inc_h_o = 4'd0;
                        end else if (h_o_q == 4'd9) begin
                            inc_h_o = 4'd0;
                            inc_h_t = h_t_q + 4'd1;
                        end else begin
                            inc_h_o = h_o_q + 4'd1;
                        end
                    end else begin
                        inc_m_t = m_t_q + 4'd1;
                    end
                end else begin
                    inc_m_o = m_o_q + 4'd1;
                end
            end else begin
                inc_s_t = s_t_q + 4'd1;
            end
        end else begin
            inc_s_o = s_o_q + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Load validation
    // ------------------------------------------------------------------
    logic [7:0] set_hour_bin;
    logic       load_ok;

    // 8 bits keep out-of-range tens digits (up to 15) from aliasing into range
    assign set_hour_bin = (8'(set_h_t) * 8'd10) + 8'(set_h_o);

    assign load_ok = (set_h_t <= 4'd9) && (set_h_o <= 4'd9) &&
                     (set_m_t <= 4'd5) && (set_m_o <= 4'd9) &&
                     (set_s_t <= 4'd5) && (set_s_o <= 4'd9) &&
                     (set_hour_bin <= 8'd23);

    // ------------------------------------------------------------------
    // Next-state: load beats tick; a rejected load freezes everything
    // for that cycle so time and prescaler stay exactly as they were
    // ------------------------------------------------------------------
    always_comb begin
        presc_d    = presc_q;
        h_t_d      = h_t_q;
        h_o_d      = h_o_q;
        m_t_d      = m_t_q;
        m_o_d      = m_o_q;
        s_t_d      = s_t_q;
        s_o_d      = s_o_q;
        sec_tick_d = 1'b0;
        day_wrap_d = 1'b0;
        load_err_d = 1'b0;

        if (load) begin
            if (load_ok) begin
                presc_d = '0;
                h_t_d   = set_h_t;
                h_o_d   = set_h_o;
                m_t_d   = set_m_t;
                m_o_d   = set_m_o;
                s_t_d   = set_s_t;
                s_o_d   = set_s_o;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (run) begin
            if (tick) begin
                presc_d    = '0;
                h_t_d      = inc_h_t;
                h_o_d      = inc_h_o;
                m_t_d      = inc_m_t;
                m_o_d      = inc_m_o;
                s_t_d      = inc_s_t;
                s_o_d      = inc_s_o;
                sec_tick_d = 1'b1;
                day_wrap_d = at_day_end;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            presc_q    <= '0;
            h_t_q      <= 4'd0;
            h_o_q      <= 4'd0;
            m_t_q      <= 4'd0;
            m_o_q      <= 4'd0;
            s_t_q      <= 4'd0;
            s_o_q      <= 4'd0;
            sec_tick_q <= 1'b0;
            day_wrap_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            h_t_q      <= h_t_d;
            h_o_q      <= h_o_d;
            m_t_q      <= m_t_d;
            m_o_q      <= m_o_d;
            s_t_q      <= s_t_d;
            s_o_q      <= s_o_d;
            sec_tick_q <= sec_tick_d;
            day_wrap_q <= day_wrap_d;
            load_err_q <= load_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Display mapping (purely combinational, never touches state)
    // ------------------------------------------------------------------
    logic [4:0] hour_bin;
    logic [4:0] hour12_bin;
    logic [3:0] hour12_t, hour12_o;

    assign hour_bin = (5'(h_t_q) * 5'd10) + 5'(h_o_q);
    assign pm       = (hour_bin >= 5'd12);

    always_comb begin
        hour12_bin = hour_bin;
        if (hour_bin == 5'd0) begin
            hour12_bin = 5'd12;
        end else if (hour_bin > 5'd12) begin
            hour12_bin = hour_bin - 5'd12;
        end
        // 12-hour values are 1..12, so a single compare gives the tens digit
        if (hour12_bin >= 5'd10) begin
            hour12_t = 4'd1;
            hour12_o = 4'(hour12_bin - 5'd10);
        end else begin
            hour12_t = 4'd0;
            hour12_o = 4'(hour12_bin);
        end
    end

    assign hours_tens   = mode_24h ? h_t_q : hour12_t;
    assign hours_ones   = mode_24h ? h_o_q : hour12_o;
    assign minutes_tens = m_t_q;
    assign minutes_ones = m_o_q;
    assign seconds_tens = s_t_q;
    assign seconds_ones = s_o_q;

    assign sec_tick = sec_tick_q;
    assign day_wrap = day_wrap_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_rtc_counter.sv
// tb/tb_rtc_counter.sv - directed self-checking bench for rtc_counter

module tb_rtc_counter;

    logic       sys_clk;
    logic       rst;
    logic       run;
    logic       mode_24h;
    logic       load;
    logic [3:0] set_h_t, set_h_o, set_m_t, set_m_o, set_s_t, set_s_o;
    logic [3:0] hours_tens, hours_ones, minutes_tens, minutes_ones;
    logic [3:0] seconds_tens, seconds_ones;
    logic       pm;
    logic       sec_tick;
    logic       day_wrap;
    logic       load_err;

    logic [23:0] disp;
    int          vectors;
    int          miscompares;
    int          tick_count;

    assign disp = {hours_tens, hours_ones, minutes_tens, minutes_ones,
                   seconds_tens, seconds_ones};

    rtc_counter #(
        .CLK_HZ (10),
        .TICK_HZ(1)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .run         (run),
        .mode_24h    (mode_24h),
        .load        (load),
        .set_h_t     (set_h_t),
        .set_h_o     (set_h_o),
        .set_m_t     (set_m_t),
        .set_m_o     (set_m_o),
        .set_s_t     (set_s_t),
        .set_s_o     (set_s_o),
        .hours_tens  (hours_tens),
        .hours_ones  (hours_ones),
        .minutes_tens(minutes_tens),
        .minutes_ones(minutes_ones),
        .seconds_tens(seconds_tens),
        .seconds_ones(seconds_ones),
        .pm          (pm),
        .sec_tick    (sec_tick),
        .day_wrap    (day_wrap),
        .load_err    (load_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic set_digits(input logic [23:0] v);
        set_h_t = v[23:20];
        set_h_o = v[19:16];
        set_m_t = v[15:12];
        set_m_o = v[11:8];
        set_s_t = v[7:4];
        set_s_o = v[3:0];
    endtask

    // Load request held for one rising edge; returns at the following negedge
    task automatic do_load(input logic [23:0] v);
        set_digits(v);
        load = 1'b1;
        @(negedge sys_clk);
        load = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst      = 1'b1;
        run      = 1'b0;
        mode_24h = 1'b1;
        load     = 1'b0;
        set_digits(24'h000000);
        cycles(2);

        // Reset state in both display modes
        chk("rst_disp24", disp, 24'h000000);
        chk("rst_pm", {23'd0, pm}, 24'd0);
        chk("rst_sec_tick", {23'd0, sec_tick}, 24'd0);
        chk("rst_day_wrap", {23'd0, day_wrap}, 24'd0);
        chk("rst_load_err", {23'd0, load_err}, 24'd0);
        mode_24h = 1'b0;
        #1;
        chk("rst_disp12", disp, 24'h120000);
        chk("rst_pm12", {23'd0, pm}, 24'd0);
        mode_24h = 1'b1;
        #1;

        // Free run: a tick on every 10th cycle
        rst = 1'b0;
        run = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            cycles(1);
            chk($sformatf("tick_pos%0d", i), {23'd0, sec_tick}, {23'd0, (i % 10) == 0});
        end
        chk("secs_after_100", disp, 24'h000010);

        // Day wrap from 23:59:58
        do_load(24'h235958);
        chk("wrap_load", disp, 24'h235958);
        chk("wrap_load_tick", {23'd0, sec_tick}, 24'd0);
        chk("wrap_load_pm", {23'd0, pm}, 24'd1);
        cycles(10);
        chk("wrap_t1", disp, 24'h235959);
        chk("wrap_t1_tick", {23'd0, sec_tick}, 24'd1);
        chk("wrap_t1_dw", {23'd0, day_wrap}, 24'd0);
        cycles(10);
        chk("wrap_t2", disp, 24'h000000);
        chk("wrap_t2_tick", {23'd0, sec_tick}, 24'd1);
        chk("wrap_t2_dw", {23'd0, day_wrap}, 24'd1);
        chk("wrap_t2_pm", {23'd0, pm}, 24'd0);
        cycles(1);
        chk("wrap_dw_gone", {23'd0, day_wrap}, 24'd0);
        chk("wrap_tick_gone", {23'd0, sec_tick}, 24'd0);

        // Valid load followed by two rejected loads
        do_load(24'h123456);
        chk("ld_ok", disp, 24'h123456);
        chk("ld_ok_err", {23'd0, load_err}, 24'd0);
        do_load(24'h240000);
        chk("ld_h24_err", {23'd0, load_err}, 24'd1);
        chk("ld_h24_time", disp, 24'h123456);
        cycles(1);
        chk("ld_h24_err_gone", {23'd0, load_err}, 24'd0);
        do_load(24'h106000);
        chk("ld_m60_err", {23'd0, load_err}, 24'd1);
        chk("ld_m60_time", disp, 24'h123456);
        cycles(1);
        chk("ld_m60_err_gone", {23'd0, load_err}, 24'd0);
        cycles(7);
        chk("ld_pre_tick", disp, 24'h123456);
        chk("ld_pre_tick_st", {23'd0, sec_tick}, 24'd0);
        cycles(1);
        chk("ld_tick", disp, 24'h123457);
        chk("ld_tick_st", {23'd0, sec_tick}, 24'd1);

        // 12-hour display mapping
        mode_24h = 1'b0;
        do_load(24'h130500);
        chk("m12_13", disp, 24'h010500);
        chk("m12_13_pm", {23'd0, pm}, 24'd1);
        do_load(24'h000000);
        chk("m12_00", disp, 24'h120000);
        chk("m12_00_pm", {23'd0, pm}, 24'd0);
        do_load(24'h120000);
        chk("m12_12", disp, 24'h120000);
        chk("m12_12_pm", {23'd0, pm}, 24'd1);
        do_load(24'h235000);
        chk("m12_23", disp, 24'h115000);
        do_load(24'h100000);
        chk("m12_10", disp, 24'h100000);
        chk("m12_10_pm", {23'd0, pm}, 24'd0);
        mode_24h = 1'b1;
        #1;
        chk("m24_back", disp, 24'h100000);

        // Load coincident with a tick
        cycles(9);
        chk("lt_pre", disp, 24'h100000);
        chk("lt_pre_st", {23'd0, sec_tick}, 24'd0);
        do_load(24'h080000);
        chk("lt_time", disp, 24'h080000);
        chk("lt_no_tick", {23'd0, sec_tick}, 24'd0);
        cycles(9);
        chk("lt_wait", disp, 24'h080000);
        chk("lt_wait_st", {23'd0, sec_tick}, 24'd0);
        cycles(1);
        chk("lt_next", disp, 24'h080001);
        chk("lt_next_st", {23'd0, sec_tick}, 24'd1);

        // Hold mid-count, then resume from the held count
        cycles(4);
        run = 1'b0;
        tick_count = 0;
        for (int i = 0; i < 50; i++) begin
            cycles(1);
            if (sec_tick) tick_count++;
        end
        chk("hold_ticks", 24'(tick_count), 24'd0);
        chk("hold_time", disp, 24'h080001);
        run = 1'b1;
        cycles(5);
        chk("resume_pre", disp, 24'h080001);
        chk("resume_pre_st", {23'd0, sec_tick}, 24'd0);
        cycles(1);
        chk("resume_tick", disp, 24'h080002);
        chk("resume_tick_st", {23'd0, sec_tick}, 24'd1);

        // Reset beats a valid load mid-count and restarts the prescaler
        cycles(3);
        set_digits(24'h111111);
        load = 1'b1;
        rst  = 1'b1;
        cycles(1);
        load = 1'b0;
        rst  = 1'b0;
        chk("rl_time", disp, 24'h000000);
        chk("rl_st", {23'd0, sec_tick}, 24'd0);
        cycles(9);
        chk("rl_pre", disp, 24'h000000);
        cycles(1);
        chk("rl_tick", disp, 24'h000001);
        chk("rl_tick_st", {23'd0, sec_tick}, 24'd1);

        // Reset beats a rejected load: no error pulse
        set_digits(24'h245959);
        load = 1'b1;
        rst  = 1'b1;
        cycles(1);
        load = 1'b0;
        rst  = 1'b0;
        chk("rb_err", {23'd0, load_err}, 24'd0);
        chk("rb_time", disp, 24'h000000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rtc_counter.md
RTC_COUNTER -- requirements
Module: rtc_counter

Interface
REQ-001 Parameter CLK_HZ, default 100000000, sys_clk frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1, timekeeping tick rate; CLK_HZ/TICK_HZ SHALL be an integer >= 2.
REQ-003 sys_clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 run  in  1  1 = time advances; 0 = prescaler and time held.
REQ-006 mode_24h  in  1  1 = 24-hour display; 0 = 12-hour display.
REQ-007 load  in  1  single-cycle request to load set_* values.
REQ-008 set_h_t, set_h_o, set_m_t, set_m_o, set_s_t, set_s_o  in  4 each  BCD load digits, always in 24-hour form.
REQ-009 hours_tens, hours_ones, minutes_tens, minutes_ones, seconds_tens, seconds_ones  out  4 each  BCD display digits.
REQ-010 pm  out  1  1 when internal hour >= 12, regardless of mode.
REQ-011 sec_tick  out  1  one-cycle pulse on each seconds increment.
REQ-012 day_wrap  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 increment.
REQ-013 load_err  out  1  one-cycle pulse when a load is rejected.

Function
REQ-014 Prescaler SHALL count 0..CLK_HZ/TICK_HZ-1 while run=1, wrapping to 0; a tick SHALL occur in the cycle the count equals its maximum.
REQ-015 While run=0 the prescaler SHALL hold its count; no tick SHALL occur.
REQ-016 Internal time SHALL be held as six BCD digits in 24-hour form; the registered update SHALL take effect at the rising edge ending the tick cycle.
REQ-017 Increment rules: s_o 9->0 carries to s_t; s_t 5->0 carries to m_o; m_o 9->0 carries to m_t; m_t 5->0 carries to hours; hours 23->00, else BCD increment (09->10, 19->20).
REQ-018 sec_tick SHALL be registered and high in the same cycle the incremented digits first appear; day_wrap SHALL be high in that same cycle only for the 23:59:59 increment.
REQ-019 Load validity: every digit <= 9, set_m_t <= 5, set_s_t <= 5, hour value (set_h_t*10+set_h_o) <= 23.
REQ-020 Valid load SHALL, at the next edge, replace all six digits and clear the prescaler to 0; sec_tick and day_wrap SHALL stay low for that cycle.
REQ-021 Invalid load SHALL leave time and prescaler unchanged and assert load_err for exactly one cycle after the load cycle.
REQ-022 Load coincident with a tick: load SHALL win; the tick SHALL be discarded.
REQ-023 Load SHALL be accepted regardless of run.
REQ-024 Display digits SHALL be combinational from internal time: mode_24h=1 passes through; mode_24h=0 maps hour 00->12, 01..12 unchanged, 13..23 -> 01..11.
REQ-025 Toggling mode_24h SHALL affect only the display mapping, never internal time or the prescaler.

Reset
REQ-026 rst=1 at a rising edge SHALL set internal time to 00:00:00, prescaler to 0, and sec_tick, day_wrap, load_err to 0.
REQ-027 rst SHALL take priority over load and tick in the same cycle, including reset in the middle of a prescaler count.
REQ-028 After reset, mode_24h=1 displays 0,0,0,0,0,0; mode_24h=0 displays 1,2,0,0,0,0; pm=0 in both.

Verification (CLK_HZ=10, TICK_HZ=1)
REQ-029 Reset, run=1, mode_24h=1 for 100 cycles -> sec_tick every 10th cycle; seconds reach 1,0 after 10 ticks.
REQ-030 Load 23:59:58, run=1 -> after 2 ticks digits 00:00:00, day_wrap high one cycle coincident with sec_tick, pm 1->0.
REQ-031 Load 12:34:56 then 24:00:00 and 10:60:00 -> first accepted; each of the others gives a one-cycle load_err with time still 12:34:56 plus elapsed ticks.
REQ-032 Load 13:05:00, mode_24h=0 -> display 01:05:00, pm=1; load 00:00:00 -> display 12:00:00, pm=0.
REQ-033 Load asserted in a tick cycle with 08:00:00 -> time 08:00:00, prescaler 0, no sec_tick; next tick follows exactly 10 cycles later.
REQ-034 run=0 for 50 cycles mid-count, then run=1 -> no ticks while held; prescaler resumes from its held value.
